data_mem_responder: RTL

//   Wait-stated data-memory responder: the target side of the CPU load/store port.

---
 rtl/data_mem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Wait-stated, byte-enabled word RAM target with address error check
// Revision : 1.0
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int                C_LANES     = DATA_W / 8;
  localparam int                C_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W-3:0] C_DEPTH     = (ADDR_W-2)'(DEPTH_WORDS);
  localparam bit                C_HAS_WAIT  = (WAIT_CYCLES > 0);
  localparam logic [3:0]        C_WAIT_INIT = C_HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 we_q;
  logic                 err_q;
  logic [C_IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [C_LANES-1:0]   be_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic [DATA_W-1:0]    rsp_rdata_q;

  logic [DATA_W-1:0]    mem [DEPTH_WORDS];

  logic                 err_d;
  logic                 mem_wr_en;

  // Address bits above the word index only feed the range check.
  always_comb begin
    err_d = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:2] >= C_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            err_q   <= err_d;
            idx_q   <= req_addr[C_IDX_W+1:2];
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt_q   <= C_WAIT_INIT;
            state_q <= C_HAS_WAIT ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          rsp_rdata_q <= (err_q || we_q) ? '0 : mem[idx_q];
          rsp_err_q   <= err_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A reset landing on the ACCESS edge must still suppress the store.
  always_comb begin
    mem_wr_en = !reset && (state_q == S_ACCESS) && !err_q && we_q;
  end

  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < C_LANES; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire
